text_video_fetch: RTL

- Text-mode video generator downstream of system_ram's dedicated read port.
- Produces 640x480@60 timing and renders an 80x60 grid of 8x8 characters.
- Per cell it fetches the character code from the screen buffer (base 0x1000), then the glyph row from the font area (base 0x0900).
- Outputs monochrome RGB plus sync signals.

---
 rtl/text_video_fetch.sv | 95 +++++++++
 1 files changed

// File: rtl/text_video_fetch.sv
// text_video_fetch: 640x480@60 text-mode generator, fetching 80x60 character cells
// and 8x8 glyph rows from a dedicated RAM read port one cell ahead of the beam.
module text_video_fetch #(
    parameter logic [14:0] SCREEN_BASE = 15'h1000,
    parameter logic [14:0] FONT_BASE   = 15'h0900,
    parameter logic [7:0]  FONT_FIRST  = 8'h20,
    parameter logic [2:0]  FG_RGB      = 3'b111,
    parameter logic [2:0]  BG_RGB      = 3'b000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [14:0] mem_addr,
    input  logic [7:0]  mem_data,
    output logic [2:0]  rgb,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic        frame_start
);
    logic [9:0]  h_q, h_d, v_q, v_d, line;
    logic [14:0] addr_q, addr_d, cell_addr, glyph_addr;
    logic [7:0]  shift_q, shift_d, next_q, next_d;
    logic [2:0]  rgb_q, rgb_d, ph;
    logic [6:0]  col;
    logic        blank_q, blank_d, hs_q, hs_d, vs_q, vs_d, von_q, von_d, fs_q, fs_d;
    logic        late, active, vis, code_ok;

    always_comb begin
        h_d        = (h_q == 10'd799) ? 10'd0 : h_q + 10'd1;
        v_d        = (h_q != 10'd799) ? v_q : (v_q == 10'd524) ? 10'd0 : v_q + 10'd1;
        ph         = h_q[2:0];
        // The last 8 clocks of a line fetch column 0 of the following line
        late       = h_q >= 10'd792;
        line       = !late ? v_q : (v_q == 10'd524) ? 10'd0 : v_q + 10'd1;
        col        = late ? 7'd0 : h_q[9:3] + 7'd1;
        active     = (line < 10'd480) && (col < 7'd80);
        code_ok    = mem_data >= FONT_FIRST;
        cell_addr  = SCREEN_BASE + 15'(line[9:3]) * 15'd80 + 15'(col);
        glyph_addr = FONT_BASE + {4'b0, mem_data - FONT_FIRST, 3'b0} + 15'(line[2:0]);
        addr_d     = addr_q;
        blank_d    = blank_q;
        next_d     = next_q;
        shift_d    = (ph == 3'd7) ? next_q : shift_q;
        if (!active)
            next_d = 8'h00;
        else if (ph == 3'd0)
            addr_d = cell_addr;
        else if (ph == 3'd2) begin
            blank_d = !code_ok;
            addr_d  = code_ok ? glyph_addr : addr_q;
        end else if (ph == 3'd4)
            next_d = blank_q ? 8'h00 : mem_data;
        vis   = (h_q < 10'd640) && (v_q < 10'd480);
        rgb_d = !vis ? 3'b000 : shift_q[~ph] ? FG_RGB : BG_RGB;
        hs_d  = !((h_q >= 10'd656) && (h_q <= 10'd751));
        vs_d  = !((v_q >= 10'd490) && (v_q <= 10'd491));
        von_d = vis;
        fs_d  = (h_q == 10'd0) && (v_q == 10'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q     <= '0;
            v_q     <= '0;
            addr_q  <= '0;
            blank_q <= 1'b0;
            next_q  <= '0;
            shift_q <= '0;
            rgb_q   <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            von_q   <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            addr_q  <= addr_d;
            blank_q <= blank_d;
            next_q  <= next_d;
            shift_q <= shift_d;
            rgb_q   <= rgb_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            von_q   <= von_d;
            fs_q    <= fs_d;
        end
    end

    assign mem_addr    = addr_q;
    assign rgb         = rgb_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign video_on    = von_q;
    assign frame_start = fs_q;
endmodule
